// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity types, legal Prescale values and line level.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESCALE_X8  = 8;
    localparam int unsigned PRESCALE_X16 = 16;
    localparam int unsigned PRESCALE_X32 = 32;

    localparam logic LINE_IDLE = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit sampler: captures the line around the bit centre and registers the 3-sample majority.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_WD = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   en,
    input  logic [PRESCALE_WD-1:0] prescale,
    input  logic [PRESCALE_WD-1:0] edge_cnt,
    output logic                   sampled_bit,
    output logic                   sample_done
);

    logic [PRESCALE_WD-1:0] half;
    logic                   s0_q;
    logic                   s1_q;

    assign half = prescale >> 1;

    // Third sample is voted in directly, so the result is valid from half+2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_q        <= LINE_IDLE;
            s1_q        <= LINE_IDLE;
            sampled_bit <= LINE_IDLE;
            sample_done <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            if (en) begin
                if (edge_cnt == half - PRESCALE_WD'(1)) s0_q <= rx;
                if (edge_cnt == half) s1_q <= rx;
                if (edge_cnt == half + PRESCALE_WD'(1)) begin
                    sampled_bit <= majority3(s0_q, s1_q, rx);
                    sample_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop deframer with error pulses.
// Define UART_RX_SYNC_EN to add a two-flop synchroniser on RX_IN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WD     = 8,
    parameter int unsigned PRESCALE_WD = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RX_IN,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESCALE_WD-1:0] Prescale,
    output logic [DATA_WD-1:0]     P_DATA,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err
);

    localparam int unsigned BIT_CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

    logic                   rx_s;
    logic [2:0]             state_q, state_d;
    logic [PRESCALE_WD-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_WD-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WD-1:0]     shift_q, shift_d;
    logic                   err_q, err_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic [PRESCALE_WD-1:0] prescale_q, prescale_d;
    logic [DATA_WD-1:0]     p_data_d;
    logic                   data_valid_d, par_err_d, stp_err_d;
    logic                   edge_last;
    logic                   exp_par;
    logic                   sampled_bit;
    logic                   sample_done;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= {2{LINE_IDLE}};
        else        sync_q <= {sync_q[0], RX_IN};
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    uart_rx_sampler #(
        .PRESCALE_WD(PRESCALE_WD)
    ) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_s),
        .en         (state_q != ST_IDLE),
        .prescale   (prescale_q),
        .edge_cnt   (edge_cnt_q),
        .sampled_bit(sampled_bit),
        .sample_done(sample_done)
    );

    assign edge_last = (edge_cnt_q == prescale_q - PRESCALE_WD'(1));
    assign exp_par   = (par_typ_q == PAR_ODD) ? ~(^shift_q) : (^shift_q);

    // Next-state, datapath and output decode.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        err_d        = err_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        prescale_d   = prescale_q;
        p_data_d     = P_DATA;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q != ST_IDLE) begin
            edge_cnt_d = edge_last ? '0 : edge_cnt_q + PRESCALE_WD'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_s != LINE_IDLE) begin
                    state_d    = ST_START;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    err_d      = 1'b0;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    prescale_d = Prescale;
                end
            end
            ST_START: begin
                if (sample_done && (sampled_bit == LINE_IDLE)) begin
                    state_d    = ST_IDLE;
                    edge_cnt_d = '0;
                end else if (edge_last) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (sample_done) shift_d[bit_cnt_q] = sampled_bit;
                if (edge_last) begin
                    if (bit_cnt_q == BIT_CNT_WD'(DATA_WD - 1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_WD'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (sample_done) err_d = (sampled_bit != exp_par);
                if (edge_last) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Exactly one outcome per frame; stop error outranks parity error.
                if (edge_last) begin
                    state_d = ST_IDLE;
                    if (sampled_bit != LINE_IDLE) begin
                        stp_err_d = 1'b1;
                    end else if (err_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            err_q      <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= '0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            err_q      <= err_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            prescale_q <= prescale_d;
            P_DATA     <= p_data_d;
            data_valid <= data_valid_d;
            par_err    <= par_err_d;
            stp_err    <= stp_err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames queue expected pulses, a monitor checks them.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned DATA_WD     = 8;
    localparam int unsigned PRESCALE_WD = 6;
    localparam logic [2:0]  EV_VALID    = 3'b100;
    localparam logic [2:0]  EV_PAR      = 3'b010;
    localparam logic [2:0]  EV_STP      = 3'b001;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   RX_IN;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [PRESCALE_WD-1:0] Prescale;
    logic [DATA_WD-1:0]     P_DATA;
    logic                   data_valid;
    logic                   par_err;
    logic                   stp_err;

    typedef struct {
        logic [2:0]         flags;
        logic [DATA_WD-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_WD    (DATA_WD),
        .PRESCALE_WD(PRESCALE_WD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_evt(input logic [2:0] flags, input logic [DATA_WD-1:0] data);
        exp_t e;
        e.flags = flags;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic b, input int unsigned p);
        RX_IN = b;
        repeat (p) @(negedge clk);
    endtask

    // Config is scrambled after the start bit; the DUT must keep the latched values.
    task automatic send_frame(input logic [DATA_WD-1:0] d, input int unsigned p, input logic pen,
                              input logic ptyp, input logic pbit, input logic stopb);
        Prescale = PRESCALE_WD'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        drive_bit(1'b0, p);
        Prescale = PRESCALE_WD'((p == PRESCALE_X8) ? PRESCALE_X16 : PRESCALE_X8);
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
        for (int i = 0; i < DATA_WD; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stopb, p);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && (data_valid || par_err || stp_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: dv=%0b pe=%0b se=%0b P_DATA=0x%0h, expected no pulse at %0t",
                         data_valid, par_err, stp_err, P_DATA, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_flags", 32'({data_valid, par_err, stp_err}), 32'(mon_e.flags));
                check("pulse_p_data", 32'(P_DATA), 32'(mon_e.data));
            end
        end
    end

    initial begin
        reset    = 1'b0;
        RX_IN    = LINE_IDLE;
        PAR_EN   = 1'b0;
        PAR_TYP  = PAR_EVEN;
        Prescale = PRESCALE_WD'(PRESCALE_X8);
        repeat (3) @(negedge clk);
        check("rst_p_data", 32'(P_DATA), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        check("rst_stp_err", 32'(stp_err), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 1: x8, no parity
        expect_evt(EV_VALID, 8'hA3);
        send_frame(8'hA3, PRESCALE_X8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        RX_IN = LINE_IDLE;
        wait_drain("t1_drain");
        check("t1_p_data", 32'(P_DATA), 32'hA3);

        // 2: x16 even parity, good then bad parity bit
        expect_evt(EV_VALID, 8'hB4);
        send_frame(8'hB4, PRESCALE_X16, 1'b1, PAR_EVEN, 1'b0, 1'b1);
        expect_evt(EV_PAR, 8'hB4);
        send_frame(8'hB4, PRESCALE_X16, 1'b1, PAR_EVEN, 1'b1, 1'b1);
        RX_IN = LINE_IDLE;
        wait_drain("t2_drain");
        check("t2_p_data_kept", 32'(P_DATA), 32'hB4);

        // 3: x32 odd parity, back-to-back frames
        expect_evt(EV_VALID, 8'hD2);
        expect_evt(EV_VALID, 8'h5A);
        send_frame(8'hD2, PRESCALE_X32, 1'b1, PAR_ODD, 1'b1, 1'b1);
        send_frame(8'h5A, PRESCALE_X32, 1'b1, PAR_ODD, 1'b1, 1'b1);
        RX_IN = LINE_IDLE;
        wait_drain("t3_drain");
        check("t3_p_data", 32'(P_DATA), 32'h5A);

        // 4: stop bit low
        expect_evt(EV_STP, 8'h5A);
        send_frame(8'h3C, PRESCALE_X8, 1'b0, PAR_EVEN, 1'b0, 1'b0);
        RX_IN = LINE_IDLE;
        wait_drain("t4_drain");
        check("t4_p_data_kept", 32'(P_DATA), 32'h5A);

        // 5: start glitch, then a good frame
        Prescale = PRESCALE_WD'(PRESCALE_X16);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (3) @(negedge clk);
        RX_IN = LINE_IDLE;
        repeat (48) @(negedge clk);
        check("t5_glitch_p_data", 32'(P_DATA), 32'h5A);
        expect_evt(EV_VALID, 8'h81);
        send_frame(8'h81, PRESCALE_X16, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        RX_IN = LINE_IDLE;
        wait_drain("t5_drain");
        check("t5_p_data", 32'(P_DATA), 32'h81);

        // 6: reset during data bit 4
        Prescale = PRESCALE_WD'(PRESCALE_X16);
        PAR_EN   = 1'b0;
        drive_bit(1'b0, PRESCALE_X16);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, PRESCALE_X16);
        RX_IN = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_p_data", 32'(P_DATA), 32'd0);
        check("t6_rst_data_valid", 32'(data_valid), 32'd0);
        check("t6_rst_par_err", 32'(par_err), 32'd0);
        check("t6_rst_stp_err", 32'(stp_err), 32'd0);
        RX_IN = LINE_IDLE;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        expect_evt(EV_VALID, 8'h66);
        send_frame(8'h66, PRESCALE_X16, 1'b0, PAR_EVEN, 1'b0, 1'b1);
        RX_IN = LINE_IDLE;
        wait_drain("t6_drain");
        check("t6_p_data", 32'(P_DATA), 32'h66);

        repeat (50) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
